// File: rtl/piso_tx.sv
// Parallel-in/serial-out UART transmitter: shifts a pre-built frame out LSB-first,
// holding each bit for OVERSAMPLE baud_clk ticks.
module piso_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int FRAME_BITS = 11
) (
    input  logic                  baud_clk,
    input  logic                  reset_n,
    input  logic                  tx_start,
    input  logic [FRAME_BITS-1:0] data_parll,
    output logic                  data_tx,
    output logic                  active_flag,
    output logic                  done_flag
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick;
    logic [BIT_W-1:0]    r_bit;
    logic                r_tx;
    logic                r_active;
    logic                r_done;
    // Holds the bits still to be sent; bit0 goes straight to r_tx at the latch.
    logic [FRAME_BITS-2:0] r_shift;

    state_t              w_state_nxt;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic                w_tx_nxt;
    logic                w_active_nxt;
    logic                w_done_nxt;
    logic                w_load;
    logic                w_shift_en;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_bit    <= w_bit_nxt;
            r_tx     <= w_tx_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Pure datapath: only ever observed after a fresh latch, so no reset needed.
    always_ff @(posedge baud_clk) begin
        if (w_load) begin
            r_shift <= data_parll[FRAME_BITS-1:1];
        end else if (w_shift_en) begin
            r_shift <= {1'b1, r_shift[FRAME_BITS-2:1]};
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick;
        w_bit_nxt    = r_bit;
        w_tx_nxt     = r_tx;
        w_active_nxt = r_active;
        w_done_nxt   = r_done;
        w_load       = 1'b0;
        w_shift_en   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt     = 1'b1;
                w_active_nxt = 1'b0;
                w_done_nxt   = 1'b0;
                if (tx_start) begin
                    w_load       = 1'b1;
                    w_tx_nxt     = data_parll[0];
                    w_active_nxt = 1'b1;
                    w_tick_nxt   = '0;
                    w_bit_nxt    = '0;
                    w_state_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_tx_nxt     = 1'b1;
                        w_active_nxt = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_bit_nxt    = '0;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_shift_en = 1'b1;
                        w_tx_nxt   = r_shift[0];
                        w_bit_nxt  = r_bit + 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            S_DONE: begin
                w_tx_nxt     = 1'b1;
                w_active_nxt = 1'b0;
                w_done_nxt   = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_tx_nxt     = 1'b1;
                w_active_nxt = 1'b0;
                w_done_nxt   = 1'b0;
                w_tick_nxt   = '0;
                w_bit_nxt    = '0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    assign data_tx     = r_tx;
    assign active_flag = r_active;
    assign done_flag   = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a default instance and an OVERSAMPLE=8 instance share stimulus,
// each checked every cycle against a frame-level queue model.
module tb_piso_tx;

    logic        baud_clk = 1'b0;
    logic        reset_n;
    logic        tx_start;
    logic [10:0] data_parll;
    logic        data_tx16, active16, done16;
    logic        data_tx8, active8, done8;

    always #5 baud_clk = ~baud_clk;

    piso_tx #(.OVERSAMPLE(16), .FRAME_BITS(11)) dut16 (
        .baud_clk(baud_clk), .reset_n(reset_n), .tx_start(tx_start),
        .data_parll(data_parll), .data_tx(data_tx16),
        .active_flag(active16), .done_flag(done16)
    );

    piso_tx #(.OVERSAMPLE(8), .FRAME_BITS(11)) dut8 (
        .baud_clk(baud_clk), .reset_n(reset_n), .tx_start(tx_start),
        .data_parll(data_parll), .data_tx(data_tx8),
        .active_flag(active8), .done_flag(done8)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Model: an idle line is {data,active,done}=100. An accepted request enqueues the whole
    // expected waveform: every frame bit for OVERSAMPLE cycles, one done cycle, one idle cycle.
    logic [2:0] q16[$];
    logic [2:0] q8[$];
    logic [2:0] exp16 = 3'b100;
    logic [2:0] exp8  = 3'b100;

    always @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            q16.delete();
            q8.delete();
            exp16 <= 3'b100;
            exp8  <= 3'b100;
        end else begin
            if (q16.size() == 0 && tx_start) begin
                for (int k = 0; k < 11; k++)
                    for (int j = 0; j < 16; j++) q16.push_back({data_parll[k], 2'b10});
                q16.push_back(3'b101);
                q16.push_back(3'b100);
            end
            if (q8.size() == 0 && tx_start) begin
                for (int k = 0; k < 11; k++)
                    for (int j = 0; j < 8; j++) q8.push_back({data_parll[k], 2'b10});
                q8.push_back(3'b101);
                q8.push_back(3'b100);
            end
            if (q16.size() != 0) exp16 <= q16.pop_front();
            else                 exp16 <= 3'b100;
            if (q8.size() != 0)  exp8 <= q8.pop_front();
            else                 exp8 <= 3'b100;
        end
    end

    always @(negedge baud_clk) begin
        if (cmp_en) begin
            chk("model16", int'({data_tx16, active16, done16}), int'(exp16));
            chk("model8", int'({data_tx8, active8, done8}), int'(exp8));
        end
    end

    logic cap16[0:399];
    logic cap8[0:399];
    int   act16, act8, dcnt16, dcnt8, dfirst16, dfirst8;

    task automatic pulse();
        @(posedge baud_clk); #1 tx_start = 1'b1;
        @(posedge baud_clk); #1 tx_start = 1'b0;
    endtask

    // mode 1: disturb inputs mid-frame; mode 2: swap data and release a held request
    task automatic capture(input int n, input int mode);
        act16 = 0; act8 = 0; dcnt16 = 0; dcnt8 = 0; dfirst16 = -1; dfirst8 = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge baud_clk);
            cap16[i] = data_tx16;
            cap8[i]  = data_tx8;
            act16 += int'(active16);
            act8  += int'(active8);
            if (done16) begin dcnt16++; if (dfirst16 < 0) dfirst16 = i; end
            if (done8)  begin dcnt8++;  if (dfirst8 < 0)  dfirst8 = i;  end
            if (mode == 1 && i == 40) begin tx_start = 1'b1; data_parll = 11'h7FE; end
            if (mode == 1 && i == 42) tx_start = 1'b0;
            if (mode == 2 && i == 50) data_parll = 11'h7FE;
            if (mode == 2 && i == 180) tx_start = 1'b0;
        end
    endtask

    function automatic int word_at(input int base, input int os, input bit use8);
        logic [10:0] w;
        for (int k = 0; k < 11; k++)
            w[k] = use8 ? cap8[base + k*os + os/2] : cap16[base + k*os + os/2];
        return int'(w);
    endfunction

    function automatic int hold_bad16(input int base);
        int bad = 0;
        for (int k = 0; k < 11; k++)
            for (int j = 0; j < 16; j++)
                if (cap16[base + k*16 + j] != cap16[base + k*16 + 8]) bad++;
        return bad;
    endfunction

    function automatic int ones16(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += int'(cap16[i]);
        return c;
    endfunction

    initial begin
        reset_n    = 1'b0;
        tx_start   = 1'b0;
        data_parll = 11'h000;

        // reset held while tx_start toggles
        @(posedge baud_clk);
        cmp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge baud_clk); #1 tx_start = ~tx_start;
            @(negedge baud_clk);
            chk("rst_data_tx", int'(data_tx16), 1);
            chk("rst_active", int'(active16), 0);
            chk("rst_done", int'(done16), 0);
        end
        @(posedge baud_clk); #1 tx_start = 1'b0; reset_n = 1'b1;
        repeat (3) @(posedge baud_clk);

        // single frame 0x54A, both oversample rates
        #1 data_parll = 11'h54A;
        pulse();
        capture(200, 0);
        chk("single_word", word_at(0, 16, 1'b0), 'h54A);
        chk("single_hold", hold_bad16(0), 0);
        chk("single_active", act16, 176);
        chk("single_done_cnt", dcnt16, 1);
        chk("single_done_at", dfirst16, 176);
        chk("single_tail_high", ones16(176, 199), 24);
        chk("os8_word", word_at(0, 8, 1'b1), 'h54A);
        chk("os8_active", act8, 88);
        chk("os8_done_at", dfirst8, 88);

        // request and data change during SHIFT are ignored
        #1 data_parll = 11'h54A;
        pulse();
        capture(200, 1);
        tx_start = 1'b0;
        chk("intf_word", word_at(0, 16, 1'b0), 'h54A);
        chk("intf_active", act16, 176);
        chk("intf_done_cnt", dcnt16, 1);
        chk("intf_tail_high", ones16(176, 199), 24);

        // back-to-back with tx_start held
        repeat (2) @(posedge baud_clk);
        #1 data_parll = 11'h54A; tx_start = 1'b1;
        @(posedge baud_clk); #1;
        capture(360, 2);
        chk("b2b_word1", word_at(0, 16, 1'b0), 'h54A);
        chk("b2b_gap_high", ones16(160, 177), 18);
        chk("b2b_start_low", ones16(178, 193), 0);
        chk("b2b_rest_high", ones16(194, 353), 160);
        chk("b2b_done_cnt", dcnt16, 2);
        chk("b2b_active", act16, 352);

        // reset during bit 4
        repeat (2) @(posedge baud_clk);
        #1 data_parll = 11'h54A;
        pulse();
        repeat (69) @(negedge baud_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_data_tx", int'(data_tx16), 1);
        chk("midrst_active", int'(active16), 0);
        chk("midrst_active8", int'(active8), 0);
        repeat (2) @(posedge baud_clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge baud_clk);
        pulse();
        capture(200, 0);
        chk("after_rst_word", word_at(0, 16, 1'b0), 'h54A);
        chk("after_rst_active", act16, 176);
        chk("after_rst_done_at", dfirst16, 176);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, baud_clk cycles per serial bit (the receiver's 16x sampling rate).
REQ-002 Parameter FRAME_BITS, default 11, frame length: start, 8 data, parity, stop.
REQ-003 baud_clk  in  1  sole clock, 16x bit-rate tick from the baud generator; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 tx_start  in  1  level request to send the frame on data_parll; sampled only in IDLE.
REQ-006 data_parll  in  FRAME_BITS  parallel frame from the framer; bit0 is sent first (start), bit10 last (stop).
REQ-007 data_tx  out  1  serial line, idle high, registered.
REQ-008 active_flag  out  1  high while a frame is being shifted out.
REQ-009 done_flag  out  1  one-cycle pulse after the last bit completes.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and DONE; all other encodings SHALL return to IDLE on the next edge.
REQ-011 IDLE: data_tx=1, active_flag=0, done_flag=0; tx_start=1 SHALL latch data_parll into the shift register, clear bit_count and tick_count, set active_flag=1 and go to SHIFT.
REQ-012 Latency: data_tx SHALL carry frame bit0 from the first edge after tx_start is sampled.
REQ-013 SHIFT: each bit SHALL be held for exactly OVERSAMPLE cycles; tick_count runs from 0 to OVERSAMPLE-1.
REQ-014 SHIFT, tick_count==OVERSAMPLE-1 and bit_count<FRAME_BITS-1: drive the next bit (LSB-first), increment bit_count and clear tick_count.
REQ-015 SHIFT, tick_count==OVERSAMPLE-1 and bit_count==FRAME_BITS-1: set data_tx=1, active_flag=0, done_flag=1 and go to DONE.
REQ-016 active_flag SHALL be high for exactly FRAME_BITS*OVERSAMPLE cycles (176 at the defaults).
REQ-017 DONE: lasts exactly one cycle with done_flag=1 and data_tx=1, then goes to IDLE and clears done_flag.
REQ-018 tx_start SHALL be ignored in SHIFT and DONE; changes on data_parll after the latch SHALL NOT affect the frame in flight.
REQ-019 tx_start held high SHALL launch frames back to back, with data_tx high for 2 extra cycles (DONE + IDLE) after each stop bit.
REQ-020 The frame SHALL be transmitted verbatim; start, parity and stop bits are not checked or generated here.
REQ-021 tick_count and bit_count SHALL be 4 bits wide at the defaults (ceil(log2) of the parameter in general) and SHALL never wrap inside SHIFT.
REQ-022 data_tx SHALL come directly from a flop, with no combinational path from any input.

Reset
REQ-023 reset_n=0 SHALL at once force state=IDLE, data_tx=1, active_flag=0, done_flag=0 and clear both counters, regardless of state.
REQ-024 Reset mid-frame SHALL abandon the frame; after release, the next accepted tx_start sends a complete frame starting at bit0.
REQ-025 The shift register contents after reset are don't-care but SHALL NOT reach data_tx before a new latch.

Verification
REQ-026 Reset: hold reset_n=0 for 3 cycles, toggling tx_start -> data_tx=1, active_flag=0, done_flag=0 throughout.
REQ-027 Single frame: data_parll=11'h54A (data 0xA5, even parity 0), 1-cycle tx_start pulse -> data_tx=0,1,0,1,0,0,1,0,1,0,1 for 16 cycles each; active_flag high 176 cycles; done_flag high for the single cycle after.
REQ-028 Interference: during SHIFT of 11'h54A, pulse tx_start and change data_parll to 11'h7FE -> serial output still 11'h54A, one done pulse, no second frame.
REQ-029 Back-to-back: tx_start held high with 11'h54A, then 11'h7FE latched at the next IDLE -> stop bit high for 16+2 cycles, then the second frame: 0, then 1 for 160 cycles.
REQ-030 Reset mid-frame: assert reset_n during bit 4 of 11'h54A -> data_tx=1 and active_flag=0 immediately; a new pulse after release sends the full 11'h54A frame.
REQ-031 Parameter: OVERSAMPLE=8 with 11'h54A -> each bit lasts 8 cycles; active_flag high 88 cycles.
